// File: rtl/ram_burst_master_if.sv
// Command, write-stream, read-stream and RAM-port bundle for ram_burst_master.
// cmd_err exists only when RBM_BOUND_CHECK_EN is defined.
interface ram_burst_master_if #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_len;
    logic          clr_req;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          done;
    logic          busy;
    logic          ram_ena;
    logic          ram_wea;
    logic          ram_flush;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          ram_read_valid;
`ifdef RBM_BOUND_CHECK_EN
    logic          cmd_err;
`endif

    modport master (
`ifdef RBM_BOUND_CHECK_EN
        output cmd_err,
`endif
        input  cmd_valid, cmd_write, cmd_base, cmd_len, clr_req,
        input  wr_valid, wr_data, rd_ready, ram_dout, ram_read_valid,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, busy,
        output ram_ena, ram_wea, ram_flush, ram_addr, ram_din
    );

    modport slave (
`ifdef RBM_BOUND_CHECK_EN
        input  cmd_err,
`endif
        output cmd_valid, cmd_write, cmd_base, cmd_len, clr_req,
        output wr_valid, wr_data, rd_ready, ram_dout, ram_read_valid,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, busy,
        input  ram_ena, ram_wea, ram_flush, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for the CBG single-port RAM: write/read bursts and flush-based clears.
// Optional RBM_BOUND_CHECK_EN rejects bursts running past DEPTH-1 and pulses cmd_err.
module ram_burst_master #(
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned AW          = 9,
    parameter int unsigned DW          = 32,
    parameter int unsigned RFIFO_DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    ram_burst_master_if.master bus
);

    localparam int unsigned PW = $clog2(RFIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StClear} state_e;

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [AW:0]   remaining_q;
    logic          outstanding_q;
    logic          tag_last_q;
    logic          done_q;
    logic [PW:0]   wptr_q;
    logic [PW:0]   rptr_q;
    logic [DW:0]   fifo_mem [RFIFO_DEPTH];

    logic [AW-1:0] addr_next;
    logic [PW:0]   fifo_count;
    logic [PW:0]   fifo_occ;
    logic [DW:0]   fifo_head;
    logic          cmd_ready, cmd_fire, cmd_skip, last_beat;
    logic          wr_fire, rd_issue, push, pop, rd_valid;

    assign addr_next  = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
    assign last_beat  = remaining_q == (AW+1)'(1);
    assign cmd_ready  = (state_q == StIdle) & ~bus.clr_req & ~rst;
    assign cmd_fire   = cmd_ready & bus.cmd_valid;
    assign wr_fire    = (state_q == StWrite) & bus.wr_valid;
    assign fifo_count = wptr_q - rptr_q;
    assign fifo_occ   = fifo_count + {{PW{1'b0}}, outstanding_q};
    // A read is only issued when its returning word already has a FIFO slot reserved.
    assign rd_issue   = (state_q == StRead) & (remaining_q != '0)
                      & (fifo_occ < (PW+1)'(RFIFO_DEPTH));
    assign push       = bus.ram_read_valid & outstanding_q;
    assign rd_valid   = fifo_count != '0;
    assign pop        = rd_valid & bus.rd_ready;
    assign fifo_head  = fifo_mem[rptr_q[PW-1:0]];

`ifdef RBM_BOUND_CHECK_EN
    logic [AW+1:0] cmd_end;
    logic          cmd_oob;
    logic          err_q;
    assign cmd_end  = (AW+2)'(bus.cmd_base) + (AW+2)'(bus.cmd_len);
    assign cmd_oob  = cmd_end > (AW+2)'(DEPTH);
    assign cmd_skip = (bus.cmd_len == '0) | cmd_oob;
`else
    assign cmd_skip = bus.cmd_len == '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= 1'b0;
            tag_last_q    <= 1'b0;
            done_q        <= 1'b0;
`ifdef RBM_BOUND_CHECK_EN
            err_q         <= 1'b0;
`endif
        end else begin
            done_q        <= 1'b0;
`ifdef RBM_BOUND_CHECK_EN
            err_q         <= cmd_fire & cmd_oob;
`endif
            outstanding_q <= rd_issue | (outstanding_q & ~bus.ram_read_valid);
            if (rd_issue) tag_last_q <= last_beat;
            unique case (state_q)
                StIdle: begin
                    if (bus.clr_req) begin
                        state_q <= StClear;
                    end else if (cmd_fire) begin
                        if (cmd_skip) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q      <= bus.cmd_base;
                            remaining_q <= bus.cmd_len;
                            state_q     <= bus.cmd_write ? StWrite : StRead;
                        end
                    end
                end
                StWrite: begin
                    if (wr_fire) begin
                        addr_q      <= addr_next;
                        remaining_q <= remaining_q - (AW+1)'(1);
                        if (last_beat) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end
                StRead: begin
                    if (rd_issue) begin
                        addr_q      <= addr_next;
                        remaining_q <= remaining_q - (AW+1)'(1);
                        if (last_beat) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (pop && fifo_head[DW]) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StClear: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + (PW+1)'(1);
            if (pop)  rptr_q <= rptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr_q[PW-1:0]] <= {tag_last_q, bus.ram_dout};
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.wr_ready  = state_q == StWrite;
    assign bus.rd_valid  = rd_valid;
    assign bus.rd_data   = rd_valid ? fifo_head[DW-1:0] : '0;
    assign bus.rd_last   = rd_valid & fifo_head[DW];
    assign bus.done      = done_q;
    assign bus.busy      = state_q != StIdle;
    assign bus.ram_ena   = wr_fire | rd_issue;
    assign bus.ram_wea   = wr_fire;
    assign bus.ram_flush = state_q == StClear;
    assign bus.ram_addr  = (wr_fire | rd_issue) ? addr_q : '0;
    assign bus.ram_din   = wr_fire ? bus.wr_data : '0;
`ifdef RBM_BOUND_CHECK_EN
    assign bus.cmd_err   = err_q;
`endif

endmodule

// File: tb/tb_ram_burst_master.sv
// Scoreboarded bench for ram_burst_master with a behavioural 1-cycle-latency RAM.
// Define RBM_BOUND_CHECK_EN to exercise the bounds-checked build.
module tb_ram_burst_master;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned RFIFO_DEPTH = 4;
`ifdef RBM_BOUND_CHECK_EN
    localparam logic [AW-1:0] BASE_A = 9'h1F4;
`else
    localparam logic [AW-1:0] BASE_A = 9'h1FE;
`endif
    localparam logic [AW-1:0] BASE_B = BASE_A + 9'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [AW+DW-1:0] exp_wr [$];
    logic [DW:0]      exp_rd [$];
    bit               exp_done [$];
    logic [DW-1:0]    ram [DEPTH];

    ram_burst_master_if #(.AW(AW), .DW(DW)) bus ();

    ram_burst_master #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .RFIFO_DEPTH(RFIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_unexpected(input string name, input logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_last, bus.done, bus.busy,
                    bus.ram_ena, bus.ram_wea, bus.ram_flush, bus.ram_addr, bus.ram_din});
    endfunction

    // RAM model: 1-cycle read latency, synchronous flush.
    always @(posedge clk) begin
        bus.ram_read_valid <= 1'b0;
        if (bus.ram_flush) begin
            for (int i = 0; i < int'(DEPTH); i++) ram[i] <= '0;
        end else if (bus.ram_ena && bus.ram_wea) begin
            ram[bus.ram_addr] <= bus.ram_din;
        end else if (bus.ram_ena) begin
            bus.ram_dout       <= ram[bus.ram_addr];
            bus.ram_read_valid <= 1'b1;
        end
    end

    // Monitor: compare every RAM write, read pop and done pulse against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ram_ena && bus.ram_wea) begin
                if (exp_wr.size() == 0) flag_unexpected("ram_wr", 64'({bus.ram_addr, bus.ram_din}));
                else check("ram_wr", 64'({bus.ram_addr, bus.ram_din}), 64'(exp_wr.pop_front()));
            end
            if (bus.rd_valid && bus.rd_ready) begin
                if (exp_rd.size() == 0) flag_unexpected("rd_word", 64'({bus.rd_last, bus.rd_data}));
                else check("rd_word", 64'({bus.rd_last, bus.rd_data}), 64'(exp_rd.pop_front()));
            end
            if (bus.done) begin
                if (exp_done.size() == 0) begin
                    flag_unexpected("done", 64'(bus.done));
                end else begin
`ifdef RBM_BOUND_CHECK_EN
                    check("cmd_err_with_done", 64'(bus.cmd_err), 64'(exp_done.pop_front()));
`else
                    void'(exp_done.pop_front());
`endif
                end
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] base, input logic [AW:0] len,
                            input logic [DW-1:0] d0, input bit gaps);
        int beat = 0;
        int cyc = 0;
        bit acc;
        for (int i = 0; i < int'(len); i++) exp_wr.push_back({base + AW'(i), d0 + DW'(i)});
        exp_done.push_back(1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_base  = base;
        bus.cmd_len   = len;
        tick();
        bus.cmd_valid = 1'b0;
        while (beat < int'(len) && cyc < 64) begin
            bus.wr_valid = !(gaps && cyc[0]);
            bus.wr_data  = d0 + DW'(beat);
            @(negedge clk);
            acc = bus.wr_valid & bus.wr_ready;
            check("wr_ram_ena", 64'(bus.ram_ena), 64'(bus.wr_valid));
            tick();
            if (acc) beat++;
            cyc++;
        end
        bus.wr_valid = 1'b0;
        check("wr_beats", 64'(beat), 64'(len));
        if (!gaps) check("wr_back_to_back", 64'(cyc), 64'(len));
        @(negedge clk);
        check("wr_done", 64'(bus.done), 64'(1));
        tick();
    endtask

    task automatic do_read(input logic [AW-1:0] base, input logic [AW:0] len, input int hold,
                           input logic [DW-1:0] head);
        int issued = 0;
        int pops = 0;
        int first = -1;
        int last = -1;
        int cyc = 0;
        bit seen_done = 1'b0;
        exp_done.push_back(1'b0);
        bus.rd_ready  = (hold == 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_base  = base;
        bus.cmd_len   = len;
        tick();
        bus.cmd_valid = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (bus.ram_ena) issued++;
            tick();
        end
        if (hold > 0) begin
            check("rd_backpressure_issues", 64'(issued), 64'(RFIFO_DEPTH));
            @(negedge clk);
            check("rd_held_valid", 64'(bus.rd_valid), 64'(1));
            check("rd_held_data", 64'(bus.rd_data), 64'(head));
            tick();
            bus.rd_ready = 1'b1;
        end
        while (!seen_done && cyc < 64) begin
            @(negedge clk);
            if (bus.rd_valid && bus.rd_ready) begin
                if (first < 0) first = cyc;
                last = cyc;
                pops++;
            end
            seen_done = bus.done;
            tick();
            cyc++;
        end
        check("rd_done_seen", 64'(seen_done), 64'(1));
        check("rd_pop_count", 64'(pops), 64'(len));
        check("rd_gapless", 64'(last - first), 64'(int'(len) - 1));
    endtask

    initial begin
        int  cyc;
        bit  seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = '0;
        bus.clr_req   = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        check("idle_busy", 64'(bus.busy), 64'(0));
        tick();

        // Wrapping write, then a write with wr_valid gaps.
        do_write(BASE_A, 10'd4, 32'hA0, 1'b0);
        do_write(BASE_B, 10'd4, 32'hB0, 1'b1);

        for (int i = 0; i < 4; i++) exp_rd.push_back({i == 3, 32'hA0 + DW'(i)});
        do_read(BASE_A, 10'd4, 0, 32'hA0);

        for (int i = 0; i < 8; i++)
            exp_rd.push_back({i == 7, (i < 4) ? 32'hA0 + DW'(i) : 32'hB0 + DW'(i - 4)});
        do_read(BASE_A, 10'd8, 10, 32'hA0);

        // Clear wins over a simultaneous command; the command follows once back in IDLE.
        bus.clr_req   = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_base  = BASE_B;
        bus.cmd_len   = 10'd1;
        @(negedge clk);
        check("clr_blocks_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        tick();
        bus.clr_req = 1'b0;
        exp_done.push_back(1'b0);
        exp_done.push_back(1'b0);
        exp_rd.push_back({1'b1, 32'h0});
        @(negedge clk);
        check("clr_flush", 64'(bus.ram_flush), 64'(1));
        check("clr_no_ena", 64'(bus.ram_ena), 64'(0));
        tick();
        @(negedge clk);
        check("clr_done", 64'(bus.done), 64'(1));
        check("clr_flush_once", 64'(bus.ram_flush), 64'(0));
        check("cmd_ready_after_clr", 64'(bus.cmd_ready), 64'(1));
        tick();
        bus.cmd_valid = 1'b0;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 32) begin
            @(negedge clk);
            seen = bus.done;
            tick();
            cyc++;
        end
        check("clr_read_done", 64'(seen), 64'(1));

        // Asynchronous reset during the 3rd beat of a 6-word write.
        exp_wr.push_back({9'h010, 32'hC0});
        exp_wr.push_back({9'h011, 32'hC1});
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_base  = 9'h010;
        bus.cmd_len   = 10'd6;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 32'hC0;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        bus.wr_data = 32'hC1;
        tick();
        bus.wr_data = 32'hC2;
        rst = 1'b1;
        #1;
        check("rst_async_outputs", outs(), 64'(0));
        bus.wr_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_no_done", 64'(bus.done), 64'(0));
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        tick();
        do_write(9'h020, 10'd1, 32'hD0, 1'b0);

        // Zero-length command completes without leaving IDLE.
        exp_done.push_back(1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_base  = 9'h005;
        bus.cmd_len   = 10'd0;
        tick();
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("len0_done", 64'(bus.done), 64'(1));
        check("len0_busy", 64'(bus.busy), 64'(0));
        check("len0_no_ena", 64'(bus.ram_ena), 64'(0));
        tick();

`ifdef RBM_BOUND_CHECK_EN
        exp_done.push_back(1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_base  = 9'h1FF;
        bus.cmd_len   = 10'd2;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 32'hEE;
        tick();
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("oob_done", 64'(bus.done), 64'(1));
        check("oob_err", 64'(bus.cmd_err), 64'(1));
        check("oob_no_ena", 64'(bus.ram_ena), 64'(0));
        check("oob_idle", 64'(bus.busy), 64'(0));
        tick();
        @(negedge clk);
        check("oob_err_pulse", 64'(bus.cmd_err), 64'(0));
        check("oob_still_no_ena", 64'(bus.ram_ena), 64'(0));
        bus.wr_valid = 1'b0;
        tick();
`else
        do_write(9'h1FF, 10'd2, 32'hE0, 1'b0);
`endif

        repeat (3) tick();
        check("wr_queue_empty", 64'(exp_wr.size()), 64'(0));
        check("rd_queue_empty", 64'(exp_rd.size()), 64'(0));
        check("done_queue_empty", 64'(exp_done.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
